coil_hbridge_driver: RTL and testbench
======================================

// Module: coil_hbridge_driver
// PURPOSE
//  Sits directly downstream of the scan-sequence decoder FSM. Converts its 4-bit amplitude and
//  positive/negative current flag into four H-bridge gate drives for the scan loop.
//  Amplitude sets a PWM duty cycle; every polarity change forces an all-off dead-time.
//  A watchdog shuts the bridge down if polarity stops toggling, so the loop never sees DC.
// PARAMETERS
//  PRESCALE   1     CLK_IN cycles per PWM tick; must be >= 1.
//  DEAD_TIME  4     cycles with all gates off after each polarity change; must be >= 1.
//  WATCHDOG   1000  max cycles in a DRIVE state without a polarity change before FAULT.
// PORTS
//  CLK_IN       in   1  single clock, shared with the decoder FSM.
//  rst          in   1  asynchronous, active-high reset.
//  amplitude    in   4  PWM duty, 0..15 sixteenths; synchronous to CLK_IN.
//  pos_current  in   1  requested polarity, 1 = positive; synchronous to CLK_IN.
//  hs_a         out  1  high-side gate, leg A (PWM in positive drive).
//  ls_a         out  1  low-side gate, leg A (static on in negative drive).
//  hs_b         out  1  high-side gate, leg B (PWM in negative drive).
//  ls_b         out  1  low-side gate, leg B (static on in positive drive).
//  active       out  1  high in DRIVE_POS or DRIVE_NEG.
//  fault        out  1  high while in FAULT.
// BEHAVIOUR
//  Reset (async): state=IDLE; all gates, active and fault 0; pol_q=1, matching the decoder's reset value.
//   Counters reset to 0.
//  All outputs are registered and update on the same edge as the state register.
//   There is no combinational path from input to output.
//  Polarity change (chg): pos_current != pol_q, sampled at a rising edge. pol_q <= pos_current on that edge.
//  States and transitions:
//   IDLE: all gates off. chg -> DEAD.
//   DEAD: all gates off. dead_cnt loads DEAD_TIME-1 on entry and decrements each cycle.
//    chg while in DEAD reloads dead_cnt and updates the target polarity.
//    When dead_cnt==0 and there is no chg: go to DRIVE_POS if pol_q=1, else DRIVE_NEG.
//    Result: gates are off for exactly DEAD_TIME cycles after the last chg.
//   DRIVE_POS: hs_a=pwm, ls_b=1, hs_b=ls_a=0.
//   DRIVE_NEG: hs_b=pwm, ls_a=1, hs_a=ls_b=0.
//    From either DRIVE state: chg -> DEAD; wd_cnt reaching WATCHDOG-1 with no chg -> FAULT.
//   FAULT: all gates off, fault=1. chg -> DEAD, and fault clears on that edge.
//   Undefined state encodings -> IDLE.
//  PWM engine:
//   pre_cnt counts 0..PRESCALE-1. phase (4 bits) increments when pre_cnt wraps.
//   Phase wraps 15 -> 0 (one period = 16*PRESCALE cycles).
//   duty is latched from amplitude on DRIVE entry (pre_cnt, phase <= 0) and at every phase wrap.
//   Amplitude changes mid-period are ignored until the next period.
//   pwm = (phase < duty). duty 0 -> high side never on; duty 15 -> on 15 of 16 ticks.
//   The low side stays on for the whole DRIVE state, including duty 0.
//  Watchdog: wd_cnt clears on chg and on DRIVE entry, increments each DRIVE cycle, and saturates.
//   Width is clog2(WATCHDOG+1).
//  Safety invariants (must hold every cycle, including reset release):
//   never hs_a&ls_a; never hs_b&ls_b; never any gate high outside DRIVE states.
//  Simultaneous events: chg has priority over watchdog expiry and over DEAD exit.
//  Reset mid-operation: all gates drop immediately on rst assertion, without waiting for a clock edge.
// TESTING (PRESCALE=1, DEAD_TIME=4, WATCHDOG=100)
//  1. Reset, then amplitude=8, pos_current held 1 for 50 cycles -> state IDLE; all gates 0; fault 0.
//  2. pos_current 1->0 at edge N, amplitude=8 -> gates 0 on edges N..N+3.
//     From N+4: ls_a=1 and hs_b high for 8 of every 16 cycles (cycles N+4..N+11 high).
//     Repeat with amplitude=0 (hs_b never high) and amplitude=15 (hs_b high 15 of 16).
//  3. In DRIVE_NEG with amplitude=4, change amplitude to 12 at phase 6 -> the current period keeps 4 high ticks.
//     The next period has 12 high ticks.
//  4. Toggle pos_current at N and again at N+2 -> DEAD restarts; DRIVE_POS (hs_a pwm, ls_b=1) begins at N+6.
//  5. Enter DRIVE_POS with no further toggles -> fault=1 and all gates 0 exactly 100 cycles after DRIVE entry.
//     A toggle then clears fault; 4 off cycles follow, then DRIVE_NEG.
//  6. Assert rst asynchronously mid-DRIVE between clock edges -> all gates 0 before the next edge.
//     Throughout all tests, an assertion checks the shoot-through invariants every cycle.

Source files
------------

// File: rtl/coil_hbridge_driver.sv
// H-bridge gate driver for the scan coil. Turns a 4-bit amplitude and a polarity flag into
// four registered gate drives: PWM on the high side, static low side, an all-off dead-time on
// every polarity change, and a watchdog that drops the bridge if polarity stops toggling.
module coil_hbridge_driver #(
    parameter int unsigned PRESCALE  = 1,
    parameter int unsigned DEAD_TIME = 4,
    parameter int unsigned WATCHDOG  = 1000
) (
    input  logic       CLK_IN,
    input  logic       rst,
    input  logic [3:0] amplitude,
    input  logic       pos_current,
    output logic       hs_a,
    output logic       ls_a,
    output logic       hs_b,
    output logic       ls_b,
    output logic       active,
    output logic       fault
);

    localparam int unsigned PreW  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned DeadW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
    localparam int unsigned WdW   = $clog2(WATCHDOG + 1);

    localparam logic [PreW-1:0]  PreMax  = PreW'(PRESCALE - 1);
    localparam logic [DeadW-1:0] DeadMax = DeadW'(DEAD_TIME - 1);
    localparam logic [WdW-1:0]   WdFire  = WdW'(WATCHDOG - 1);
    localparam logic [WdW-1:0]   WdSat   = WdW'(WATCHDOG);

    typedef enum logic [2:0] {
        StIdle,
        StDead,
        StDrivePos,
        StDriveNeg,
        StFault
    } state_e;

    state_e           state_q, state_d;
    logic             pol_q;
    logic [DeadW-1:0] dead_q, dead_d;
    logic [WdW-1:0]   wd_q, wd_d;
    logic [PreW-1:0]  pre_q, pre_d;
    logic [3:0]       phase_q, phase_d;
    logic [3:0]       duty_q, duty_d;
    logic             hs_a_q, ls_a_q, hs_b_q, ls_b_q, active_q, fault_q;
    logic             hs_a_d, ls_a_d, hs_b_d, ls_b_d, active_d, fault_d;
    logic             chg;
    logic             pwm_d;

    assign chg = (pos_current != pol_q);

    // Next-state, counters and PWM engine; chg outranks watchdog expiry and dead-time exit.
    always_comb begin
        state_d = state_q;
        dead_d  = dead_q;
        wd_d    = wd_q;
        pre_d   = pre_q;
        phase_d = phase_q;
        duty_d  = duty_q;

        unique case (state_q)
            StIdle: begin
                if (chg) begin
                    state_d = StDead;
                    dead_d  = DeadMax;
                end
            end
            StDead: begin
                if (chg) begin
                    dead_d = DeadMax;
                end else if (dead_q == '0) begin
                    state_d = pol_q ? StDrivePos : StDriveNeg;
                    wd_d    = '0;
                    pre_d   = '0;
                    phase_d = '0;
                    duty_d  = amplitude;
                end else begin
                    dead_d = dead_q - 1'b1;
                end
            end
            StDrivePos, StDriveNeg: begin
                if (chg) begin
                    state_d = StDead;
                    dead_d  = DeadMax;
                end else if (wd_q == WdFire) begin
                    state_d = StFault;
                end else begin
                    if (wd_q != WdSat) begin
                        wd_d = wd_q + 1'b1;
                    end
                    if (pre_q == PreMax) begin
                        pre_d   = '0;
                        phase_d = phase_q + 1'b1;
                        // New duty only takes effect at a period boundary.
                        if (phase_q == 4'hf) begin
                            duty_d = amplitude;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
            end
            StFault: begin
                if (chg) begin
                    state_d = StDead;
                    dead_d  = DeadMax;
                end
            end
            default: state_d = StIdle;
        endcase

        if (chg) begin
            wd_d = '0;
        end
    end

    // Output decode from the next state so outputs register on the same edge as the state.
    always_comb begin
        hs_a_d   = 1'b0;
        ls_a_d   = 1'b0;
        hs_b_d   = 1'b0;
        ls_b_d   = 1'b0;
        active_d = 1'b0;
        fault_d  = 1'b0;
        pwm_d    = (phase_d < duty_d);
        unique case (state_d)
            StDrivePos: begin
                hs_a_d   = pwm_d;
                ls_b_d   = 1'b1;
                active_d = 1'b1;
            end
            StDriveNeg: begin
                hs_b_d   = pwm_d;
                ls_a_d   = 1'b1;
                active_d = 1'b1;
            end
            StFault: fault_d = 1'b1;
            default: ;
        endcase
    end

    // State, counters and output registers; async reset drops the gates immediately.
    always_ff @(posedge CLK_IN or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            pol_q    <= 1'b1;
            dead_q   <= '0;
            wd_q     <= '0;
            pre_q    <= '0;
            phase_q  <= '0;
            duty_q   <= '0;
            hs_a_q   <= 1'b0;
            ls_a_q   <= 1'b0;
            hs_b_q   <= 1'b0;
            ls_b_q   <= 1'b0;
            active_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pol_q    <= pos_current;
            dead_q   <= dead_d;
            wd_q     <= wd_d;
            pre_q    <= pre_d;
            phase_q  <= phase_d;
            duty_q   <= duty_d;
            hs_a_q   <= hs_a_d;
            ls_a_q   <= ls_a_d;
            hs_b_q   <= hs_b_d;
            ls_b_q   <= ls_b_d;
            active_q <= active_d;
            fault_q  <= fault_d;
        end
    end

    assign hs_a   = hs_a_q;
    assign ls_a   = ls_a_q;
    assign hs_b   = hs_b_q;
    assign ls_b   = ls_b_q;
    assign active = active_q;
    assign fault  = fault_q;

endmodule

// File: tb/tb_coil_hbridge_driver.sv
// Directed bench for coil_hbridge_driver with PRESCALE=1, DEAD_TIME=4, WATCHDOG=100.
module tb_coil_hbridge_driver;

    logic       CLK_IN = 1'b0;
    logic       rst;
    logic [3:0] amplitude;
    logic       pos_current;
    logic       hs_a, ls_a, hs_b, ls_b, active, fault;

    int checks = 0;
    int errors = 0;

    coil_hbridge_driver #(
        .PRESCALE (1),
        .DEAD_TIME(4),
        .WATCHDOG (100)
    ) dut (
        .CLK_IN     (CLK_IN),
        .rst        (rst),
        .amplitude  (amplitude),
        .pos_current(pos_current),
        .hs_a       (hs_a),
        .ls_a       (ls_a),
        .hs_b       (hs_b),
        .ls_b       (ls_b),
        .active     (active),
        .fault      (fault)
    );

    always #5 CLK_IN = ~CLK_IN;

    // Shoot-through and gates-only-while-active invariants, checked every cycle.
    always @(negedge CLK_IN) begin
        checks++;
        assert (!(hs_a && ls_a) && !(hs_b && ls_b) && (active || !(hs_a | ls_a | hs_b | ls_b)))
        else begin
            errors++;
            $error("FAIL invariant got gates=%b active=%b exp safe", {hs_a, ls_a, hs_b, ls_b},
                   active);
        end
    end

    task automatic step();
        @(posedge CLK_IN);
        #1;
    endtask

    // Compares {hs_a, ls_a, hs_b, ls_b, active, fault}.
    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] got;
        got = {hs_a, ls_a, hs_b, ls_b, active, fault};
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask

    // One 16-cycle period in DRIVE_NEG with duty d.
    task automatic period_neg(input string tag, input int d);
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("%s_ph%0d", tag, i), {1'b0, 1'b1, (i < d), 1'b0, 1'b1, 1'b0});
        end
    endtask

    initial begin
        rst         = 1'b1;
        amplitude   = 4'd8;
        pos_current = 1'b1;
        #1;
        chk("reset_async", 6'b000000);
        step();
        step();
        rst = 1'b0;

        // 1: steady polarity stays idle
        for (int i = 0; i < 50; i++) step();
        chk("idle_50", 6'b000000);

        // 2: 1->0, dead-time then DRIVE_NEG at duty 8, 0, 15
        pos_current = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("dead_neg_%0d", i), 6'b000000);
        end
        period_neg("neg_d8", 8);
        amplitude = 4'd0;
        period_neg("neg_d0", 0);
        amplitude = 4'd15;
        period_neg("neg_d15", 15);

        // 3: mid-period amplitude change held off to next period
        amplitude = 4'd4;
        for (int i = 0; i < 16; i++) begin
            step();
            chk($sformatf("neg_d4_ph%0d", i), {1'b0, 1'b1, (i < 4), 1'b0, 1'b1, 1'b0});
            if (i == 6) amplitude = 4'd12;
        end
        period_neg("neg_d12", 12);

        // Move to DRIVE_POS
        pos_current = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("dead_pos_%0d", i), 6'b000000);
        end
        step();
        chk("pos_entry", 6'b100110);
        step();
        step();

        // 4: double toggle restarts dead-time
        pos_current = 1'b0;
        step();
        chk("dbl_N", 6'b000000);
        step();
        chk("dbl_N1", 6'b000000);
        pos_current = 1'b1;
        for (int i = 2; i < 6; i++) begin
            step();
            chk($sformatf("dbl_N%0d", i), 6'b000000);
        end
        step();
        chk("dbl_N6_pos", 6'b100110);

        // 5: watchdog fires exactly 100 cycles after DRIVE entry
        for (int i = 1; i < 100; i++) step();
        chk("wd_99_still_drive", {(4'd3 < 4'd12), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        step();
        chk("wd_100_fault", 6'b000001);
        step();
        chk("fault_hold", 6'b000001);
        pos_current = 1'b0;
        step();
        chk("fault_clear", 6'b000000);
        for (int i = 1; i < 4; i++) begin
            step();
            chk($sformatf("fault_dead_%0d", i), 6'b000000);
        end
        step();
        chk("fault_neg_entry", 6'b011010);

        // 6: async reset mid-drive
        step();
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_gates", 6'b000000);
        step();
        rst = 1'b0;
        step();
        step();
        chk("after_rst_idle", 6'b000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
